writeback_proc: RTL and testbench
=================================

# writeback_proc

Write-back stage of the single-cycle Y86-64 SEQ processor, and the write side of the register file that the decode stage reads. Each valid cycle it takes the executed instruction's code, register specifiers, `val_e`, `val_m` and condition flag, then updates up to two registers on the rising clock edge. It tracks processor status, including freezing on `halt` or an invalid instruction, and counts retired instructions. A debug read port exposes register contents.

## Interface
Parameters:
- `XLEN`, 64: data width of registers and values.
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  instruction present this cycle.
- `in_code`  in  4  icode.
- `in_fun`  in  4  ifun; informational only, since `cnd` already resolves cmov.
- `cnd`  in  1  condition result from execute; gates cmov.
- `ra`  in  4  rA specifier.
- `rb`  in  4  rB specifier.
- `val_e`  in  XLEN  ALU result.
- `val_m`  in  XLEN  memory read result.
- `dbg_addr`  in  4  debug read register index.
- `dbg_data`  out  XLEN  register[`dbg_addr`], combinational; 0 when `dbg_addr`=0xF.
- `stat`  out  3  AOK=1, HLT=2, INS=4.
- `retired`  out  CNT_W  count of retired instructions.

## Operation
- Register file: 15 × XLEN entries (indices 0–14). Index 0xF (RNONE) is never written. Register 4 is %rsp.
- dstE selection:
  - icode 2 with `cnd`=1 → `rb`.
  - icode 2 with `cnd`=0 → RNONE.
  - icode 3 or 6 → `rb`.
  - icode 8, 9, A or B → 4.
  - Otherwise → RNONE.
- dstM selection: icode 5 or B → `ra`; otherwise RNONE.
- Writes: reg[dstE] ← `val_e`, then reg[dstM] ← `val_m`, in the same edge. If dstE == dstM and neither is RNONE (popq %rsp), `val_m` wins.
- Status FSM (`stat`):
  - AOK, valid, icode 0 (halt) → HLT. No register write. `retired` +1.
  - AOK, valid, icode > 0xB → INS. No register write. `retired` unchanged.
  - AOK, valid, icode 1–B → stay AOK. Perform writes. `retired` +1.
  - HLT and INS are terminal until reset. All inputs are ignored, with no writes and no count.
  - `in_valid`=0 → no state change.
- `retired` wraps modulo 2^CNT_W.
- `dbg_data` reflects the current register contents only. There is no bypass of same-cycle write data.

## Timing
- Reset (async assert, any time including mid-write): all 15 registers ← 0, `stat` ← AOK, `retired` ← 0. Outputs take these values immediately while `reset_n`=0.
- Reset deassertion is synchronous in effect: the first edge with `reset_n`=1 may perform a write.
- Latency: inputs are sampled at a rising edge; the written value is visible on `dbg_data` after that edge (0-cycle combinational read of the stored value). `stat` and `retired` also update at that edge.
- One instruction per cycle. There is no handshake or backpressure; the block always accepts.
- Transition to HLT/INS takes effect at the same edge as the offending instruction. The next valid instruction is already blocked.

## Structure
- Shared package `y86_pkg`:
  - icode constants IHALT…IPOPQ.
  - RNONE=4'hF and RRSP=4'h4.
  - stat codes SAOK/SHLT/SINS.
  - Used by the decode, execute and writeback stages.
- Sub-module `y86_regfile`: 15 × XLEN storage with two write ports (E, then M, M priority) and one combinational read port, plus async active-low clear. Decode instantiates a shared copy through its read ports later.
- Top level holds the dst selection logic, the status FSM and the counter.

## Test plan
- Reset, then `dbg_addr`=0..14 → `dbg_data`=0 for every register, `stat`=1, `retired`=0.
- irmovq (icode 3, `rb`=2, `val_e`=0x2A) → reg2=0x2A after the edge, `retired`=1. Then cmov (icode 2, `ra`=2, `rb`=3, `cnd`=0, `val_e`=0x2A) → reg3 unchanged at 0, `retired`=2.
- popq %rsp (icode B, `ra`=4, `val_e`=0x108, `val_m`=0x77) → reg4=0x77. Then mrmovq (icode 5, `ra`=6, `val_m`=0xDEAD) → reg6=0xDEAD, reg4 unchanged.
- halt (icode 0), then OPq (icode 6, `rb`=1, `val_e`=5) → `stat`=2, reg1 stays 0, `retired` increments only for the halt.
- Invalid icode 0xC → `stat`=4, `retired` unchanged. Then assert `reset_n`=0 mid-cycle → `stat`=1 and all registers 0 immediately, without waiting for a clock edge.
- Preload `retired`=2^CNT_W−1 via a reduced CNT_W=4 build with 15 nops, then one more nop → `retired`=0 and `stat` stays AOK.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register ids, status codes
// and the destination-register selection rules used by the pipeline stages.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  typedef enum logic [2:0] {
    SAOK = 3'd1,
    SHLT = 3'd2,
    SINS = 3'd4
  } stat_t;

  // cmov (rrmovq) only writes its destination when the condition held
  function automatic logic [3:0] dst_e_sel(input logic [3:0] code,
                                           input logic       cnd,
                                           input logic [3:0] rb);
    logic [3:0] d;
    d = RNONE;
    case (code)
      IRRMOVQ:                     d = cnd ? rb : RNONE;
      IIRMOVQ, IOPQ:               d = rb;
      ICALL, IRET, IPUSHQ, IPOPQ:  d = RRSP;
      default:                     d = RNONE;
    endcase
    return d;
  endfunction

  function automatic logic [3:0] dst_m_sel(input logic [3:0] code,
                                           input logic [3:0] ra);
    return (code == IMRMOVQ || code == IPOPQ) ? ra : RNONE;
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// 15-entry register file: two write ports (M beats E on the same index),
// one combinational read port, async active-low clear. RNONE never stores.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            we_e,
  input  logic [3:0]      dst_e,
  input  logic [XLEN-1:0] data_e,
  input  logic            we_m,
  input  logic [3:0]      dst_m,
  input  logic [XLEN-1:0] data_m,
  input  logic [3:0]      rd_addr,
  output logic [XLEN-1:0] rd_data
);

  localparam int NREGS = 15;

  logic [NREGS-1:0][XLEN-1:0] regs;

  // Index 15 has no storage, so an RNONE destination matches no entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we_m && dst_m == 4'(i))      regs[i] <= data_m;
        else if (we_e && dst_e == 4'(i)) regs[i] <= data_e;
      end
    end
  end

  assign rd_data = (rd_addr == RNONE) ? '0 : regs[rd_addr];

endmodule

// File: rtl/writeback_proc.sv
// SEQ write-back stage: destination selection, register file writes,
// processor status FSM and retired-instruction counter.
module writeback_proc
  import y86_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [3:0]       in_code,
  input  logic [3:0]       in_fun,
  input  logic             cnd,
  input  logic [3:0]       ra,
  input  logic [3:0]       rb,
  input  logic [XLEN-1:0]  val_e,
  input  logic [XLEN-1:0]  val_m,
  input  logic [3:0]       dbg_addr,
  output logic [XLEN-1:0]  dbg_data,
  output logic [2:0]       stat,
  output logic [CNT_W-1:0] retired
);

  stat_t      stat_q;
  logic       accept;
  logic       is_halt;
  logic       is_bad;
  logic       do_write;
  logic [3:0] dst_e;
  logic [3:0] dst_m;
  logic       unused_fun;

  // cnd already resolves the cmov variant, so ifun carries no extra meaning here
  assign unused_fun = ^in_fun;

  assign accept   = in_valid && (stat_q == SAOK);
  assign is_halt  = (in_code == IHALT);
  assign is_bad   = (in_code > IPOPQ);
  assign do_write = accept && !is_halt && !is_bad;

  assign dst_e = dst_e_sel(in_code, cnd, rb);
  assign dst_m = dst_m_sel(in_code, ra);

  y86_regfile #(.XLEN(XLEN)) u_regfile (
    .clock   (clock),
    .reset_n (reset_n),
    .we_e    (do_write),
    .dst_e   (dst_e),
    .data_e  (val_e),
    .we_m    (do_write),
    .dst_m   (dst_m),
    .data_m  (val_m),
    .rd_addr (dbg_addr),
    .rd_data (dbg_data)
  );

  // HLT and INS are sticky; only reset returns to AOK.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_q  <= SAOK;
      retired <= '0;
    end else if (accept) begin
      if (is_halt) begin
        stat_q  <= SHLT;
        retired <= retired + CNT_W'(1);
      end else if (is_bad) begin
        stat_q  <= SINS;
      end else begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

  assign stat = stat_q;

endmodule

// File: tb/tb_writeback_proc.sv
// Randomized + directed bench for writeback_proc against a behavioural model;
// a narrow-counter copy shares the stimulus to exercise counter wrap.
module tb_writeback_proc;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  in_code = 4'h1;
  logic [3:0]  in_fun = 4'h0;
  logic        cnd = 1'b0;
  logic [3:0]  ra = 4'hF;
  logic [3:0]  rb = 4'hF;
  logic [63:0] val_e = '0;
  logic [63:0] val_m = '0;
  logic [3:0]  dbg_addr = 4'h0;
  logic [63:0] dbg_data, dbg_data4;
  logic [2:0]  stat, stat4;
  logic [31:0] retired;
  logic [3:0]  retired4;

  writeback_proc #(.XLEN(64), .CNT_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_code(in_code),
    .in_fun(in_fun), .cnd(cnd), .ra(ra), .rb(rb), .val_e(val_e), .val_m(val_m),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .stat(stat), .retired(retired)
  );

  writeback_proc #(.XLEN(64), .CNT_W(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_code(in_code),
    .in_fun(in_fun), .cnd(cnd), .ra(ra), .rb(rb), .val_e(val_e), .val_m(val_m),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data4), .stat(stat4), .retired(retired4)
  );

  always #5 clock = ~clock;

  // behavioural model
  logic [63:0]     m_reg [15];
  int              m_stat;
  longint unsigned m_ret;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 15; i++) m_reg[i] = '0;
    m_stat = 1;
    m_ret  = 0;
  endfunction

  function automatic void model_step(input bit v, input int code, input bit c,
                                     input int a, input int b,
                                     input logic [63:0] ve, input logic [63:0] vm);
    int de, dm;
    if (!v || m_stat != 1) return;
    if (code == 0) begin m_stat = 2; m_ret++; return; end
    if (code > 11) begin m_stat = 4; return; end
    de = 15;
    dm = 15;
    if ((code == 2 && c) || code == 3 || code == 6) de = b;
    else if (code >= 8) de = 4;
    if (code == 5 || code == 11) dm = a;
    if (de != 15) m_reg[de] = ve;
    if (dm != 15) m_reg[dm] = vm;
    m_ret++;
  endfunction

  // per-cycle comparison against the model
  always @(negedge clock) begin
    logic [63:0] exp_dbg;
    if (chk_en) begin
      exp_dbg = (dbg_addr == 4'hF) ? 64'd0 : m_reg[dbg_addr];
      check("dbg_data", dbg_data, exp_dbg);
      check("dbg_data_w4", dbg_data4, exp_dbg);
      check("stat", {61'd0, stat}, 64'(m_stat));
      check("stat_w4", {61'd0, stat4}, 64'(m_stat));
      check("retired", {32'd0, retired}, m_ret & 64'hFFFF_FFFF);
      check("retired_w4", {60'd0, retired4}, m_ret % 16);
    end
  end

  task automatic step(input bit v, input logic [3:0] code, input bit c,
                      input logic [3:0] a, input logic [3:0] b,
                      input logic [63:0] ve, input logic [63:0] vm, input logic [3:0] da);
    @(negedge clock); #1;
    in_valid = v; in_code = code; in_fun = 4'($urandom_range(0, 15)); cnd = c;
    ra = a; rb = b; val_e = ve; val_m = vm; dbg_addr = da;
    @(posedge clock);
    model_step(v, int'(code), c, int'(a), int'(b), ve, vm);
  endtask

  task automatic peek(input string name, input logic [3:0] a, input logic [63:0] exp);
    @(negedge clock); #1;
    in_valid = 1'b0;
    dbg_addr = a;
    #1;
    check(name, dbg_data, exp);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    in_valid = 1'b0;
    reset_n = 1'b0;
    model_reset();
    for (int a = 0; a < 15; a++) begin
      dbg_addr = 4'(a);
      #1;
      check("reset_dbg", dbg_data, 64'd0);
    end
    check("reset_stat", {61'd0, stat}, 64'd1);
    check("reset_retired", {32'd0, retired}, 64'd0);
    @(negedge clock); #1;
    reset_n = 1'b1;
    chk_en = 1'b1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int term_cycles;
    #1;
    do_reset();

    // irmovq then a not-taken cmov
    step(1, 4'h3, 0, 4'hF, 4'h2, 64'h2A, 64'h0, 4'h2);
    peek("irmovq_reg2", 4'h2, 64'h2A);
    check("irmovq_retired", {32'd0, retired}, 64'd1);
    step(1, 4'h2, 0, 4'h2, 4'h3, 64'h2A, 64'h0, 4'h3);
    peek("cmov_nc_reg3", 4'h3, 64'h0);
    check("cmov_retired", {32'd0, retired}, 64'd2);

    // popq %rsp: memory value wins over the incremented stack pointer
    step(1, 4'hB, 0, 4'h4, 4'hF, 64'h108, 64'h77, 4'h4);
    peek("popq_rsp_reg4", 4'h4, 64'h77);
    step(1, 4'h5, 0, 4'h6, 4'hF, 64'h0, 64'hDEAD, 4'h6);
    peek("mrmovq_reg6", 4'h6, 64'hDEAD);
    peek("mrmovq_reg4_kept", 4'h4, 64'h77);

    // halt freezes the machine
    step(1, 4'h0, 0, 4'hF, 4'hF, 64'h0, 64'h0, 4'h1);
    step(1, 4'h6, 0, 4'hF, 4'h1, 64'h5, 64'h0, 4'h1);
    peek("after_halt_reg1", 4'h1, 64'h0);
    check("halt_stat", {61'd0, stat}, 64'd2);
    check("halt_retired", {32'd0, retired}, 64'd5);

    // invalid instruction, then asynchronous reset in the middle of a cycle
    do_reset();
    step(1, 4'h3, 0, 4'hF, 4'h7, 64'h55, 64'h0, 4'h7);
    step(1, 4'hC, 0, 4'h1, 4'h2, 64'h9, 64'h9, 4'h7);
    peek("ins_reg7", 4'h7, 64'h55);
    check("ins_stat", {61'd0, stat}, 64'd4);
    check("ins_retired", {32'd0, retired}, 64'd1);
    @(posedge clock); #3;
    chk_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async_rst_stat", {61'd0, stat}, 64'd1);
    check("async_rst_reg7", dbg_data, 64'd0);
    check("async_rst_retired", {32'd0, retired}, 64'd0);
    do_reset();

    // counter wrap on the narrow copy
    for (int i = 0; i < 15; i++) step(1, 4'h1, 0, 4'hF, 4'hF, 64'h0, 64'h0, 4'h0);
    peek("wrap_pre_reg0", 4'h0, 64'h0);
    check("wrap_pre_retired4", {60'd0, retired4}, 64'd15);
    step(1, 4'h1, 0, 4'hF, 4'hF, 64'h0, 64'h0, 4'h0);
    peek("wrap_reg0", 4'h0, 64'h0);
    check("wrap_retired4", {60'd0, retired4}, 64'd0);
    check("wrap_stat4", {61'd0, stat4}, 64'd1);
    check("wrap_retired32", {32'd0, retired}, 64'd16);

    // randomized traffic
    term_cycles = 0;
    for (int n = 0; n < 1500; n++) begin
      int r;
      logic [3:0] code;
      r = $urandom_range(0, 99);
      if (r < 2)      code = 4'h0;
      else if (r < 4) code = 4'($urandom_range(12, 15));
      else            code = 4'($urandom_range(1, 11));
      step($urandom_range(0, 9) != 0, code, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom_range(0, 15)));
      if (m_stat != 1) term_cycles++;
      if (term_cycles > 8) begin
        term_cycles = 0;
        do_reset();
      end
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
